// File: rtl/sprite_pkg.sv
// Shared geometry constants and pixel-line helpers for the sprite store.
// The store is configured here; the font ROM fixes ROM sprites at 8x16.
package sprite_pkg;
  localparam int NUM_SPRITES   = 256;
  localparam int ROM_SPRITES   = 128;
  localparam int SPR_W         = 8;
  localparam int SPR_H         = 16;
  localparam int BPP           = 2;
  localparam int IW            = $clog2(NUM_SPRITES);
  localparam int LW            = $clog2(SPR_H);
  localparam int LINE_W        = SPR_W * BPP;
  localparam int LPW           = 32 / LINE_W;
  localparam int SW            = (LPW > 1) ? $clog2(LPW) : 1;
  localparam int WORDS_PER_SPR = SPR_H / LPW;
  localparam int RAM_WORDS     = (NUM_SPRITES - ROM_SPRITES) * WORDS_PER_SPR;
  localparam int AW            = $clog2(RAM_WORDS);
  localparam int ROM_AW        = $clog2(ROM_SPRITES * SPR_H);

  function automatic logic [LINE_W-1:0] expand_1bpp(input logic [7:0] b);
    logic [LINE_W-1:0] line;
    line = '0;
    for (int i = 0; i < SPR_W; i++) line[i*BPP +: BPP] = {BPP{b[i]}};
    return line;
  endfunction

  function automatic logic [LINE_W-1:0] hflip_line(input logic [LINE_W-1:0] d);
    logic [LINE_W-1:0] line;
    line = '0;
    for (int p = 0; p < SPR_W; p++) line[p*BPP +: BPP] = d[(SPR_W-1-p)*BPP +: BPP];
    return line;
  endfunction
endpackage

// File: rtl/font_rom.sv
// Registered 1bpp glyph ROM, 128 glyphs x 16 lines, bit i = pixel i.
// Only a few glyphs are populated; all other lines read as blank.
module font_rom (
  input  logic        i_clk,
  input  logic [10:0] i_addr,
  output logic [7:0]  o_data
);
  function automatic logic [7:0] glyph(input logic [10:0] a);
    case (a)
      11'h412: glyph = 8'h18;
      11'h413: glyph = 8'h3C;
      11'h414: glyph = 8'h66;
      11'h415: glyph = 8'h66;
      11'h416: glyph = 8'h7E;
      11'h417: glyph = 8'h66;
      11'h418: glyph = 8'h66;
      11'h419: glyph = 8'h66;
      11'h2EB: glyph = 8'h01;
      11'h2EC: glyph = 8'h01;
      default: glyph = 8'h00;
    endcase
  endfunction

  always_ff @(posedge i_clk) o_data <= glyph(i_addr);
endmodule

// File: rtl/sprite_fetch_arb.sv
// Round-robin arbiter: r_ptr is the highest-priority channel, moved to the
// channel after the winner whenever a grant is issued.
module sprite_fetch_arb #(
  parameter int NUM_PORTS = 2,
  parameter int CW        = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [NUM_PORTS-1:0] i_req,
  output logic [NUM_PORTS-1:0] o_gnt,
  output logic [CW-1:0]        o_idx,
  output logic                 o_any
);
  logic [CW-1:0] r_ptr;
  int            w_c;

  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_c   = 0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      w_c = (int'(r_ptr) + i) % NUM_PORTS;
      if (!o_any && i_req[w_c]) begin
        o_any      = 1'b1;
        o_gnt[w_c] = 1'b1;
        o_idx      = CW'(w_c);
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_ptr <= '0;
    else if (o_any) r_ptr <= (int'(o_idx) == NUM_PORTS - 1) ? '0 : o_idx + CW'(1);
  end
endmodule

// File: rtl/sprite_store.sv
// Sprite store: font ROM glyphs plus Avalon-writable RAM sprites, read by
// NUM_PORTS line-fetch channels through one shared, arbitrated RAM read port.
module sprite_store
  import sprite_pkg::*;
#(
  parameter int NUM_PORTS = 2
) (
  input  logic                        CLK_100,
  input  logic                        RESET,
  input  logic                        AVL_CS,
  input  logic                        AVL_READ,
  input  logic                        AVL_WRITE,
  input  logic [3:0]                  AVL_BYTE_EN,
  input  logic [AW-1:0]               AVL_ADDR,
  input  logic [31:0]                 AVL_WRITEDATA,
  output logic [31:0]                 AVL_READDATA,
  input  logic [NUM_PORTS-1:0]        fetch_req,
  input  logic [NUM_PORTS*IW-1:0]     fetch_index,
  input  logic [NUM_PORTS*LW-1:0]     fetch_line,
  input  logic [NUM_PORTS-1:0]        fetch_hflip,
  output logic [NUM_PORTS-1:0]        fetch_gnt,
  output logic [NUM_PORTS-1:0]        fetch_valid,
  output logic [NUM_PORTS*LINE_W-1:0] fetch_data
);
  localparam int CW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [31:0]                 r_mem [RAM_WORDS];
  logic [31:0]                 r_readdata;
  logic [31:0]                 r_ram_q;
  logic                        r_s1_vld;
  logic [CW-1:0]               r_s1_ch;
  logic                        r_s1_rom;
  logic [SW-1:0]               r_s1_slot;
  logic                        r_s1_hflip;
  logic [NUM_PORTS-1:0]        r_valid;
  logic [NUM_PORTS*LINE_W-1:0] r_data;

  logic [CW-1:0]     w_gnt_ch;
  logic              w_any_gnt;
  logic [IW-1:0]     w_idx_sel;
  logic [IW-1:0]     w_rel;
  logic [LW-1:0]     w_line_sel;
  logic [AW-1:0]     w_ram_addr;
  logic [ROM_AW-1:0] w_rom_addr;
  logic [7:0]        w_font_byte;
  logic [LINE_W-1:0] w_raw;
  logic [LINE_W-1:0] w_line_out;

  sprite_fetch_arb #(.NUM_PORTS(NUM_PORTS), .CW(CW)) u_arb (
    .i_clk (CLK_100),
    .i_rst (RESET),
    .i_req (fetch_req),
    .o_gnt (fetch_gnt),
    .o_idx (w_gnt_ch),
    .o_any (w_any_gnt)
  );

  assign w_idx_sel  = fetch_index[w_gnt_ch*IW +: IW];
  assign w_line_sel = fetch_line[w_gnt_ch*LW +: LW];
  assign w_rel      = w_idx_sel - IW'(ROM_SPRITES);
  assign w_ram_addr = AW'(int'(w_rel) * WORDS_PER_SPR + int'(w_line_sel) / LPW);
  assign w_rom_addr = ROM_AW'(int'(w_idx_sel) * SPR_H + int'(w_line_sel));

  font_rom u_font (
    .i_clk  (CLK_100),
    .i_addr (w_rom_addr),
    .o_data (w_font_byte)
  );

  // Both ports sample the array before this edge's write lands, so a fetch
  // granted in the same cycle as an AVL write to its word sees the old word.
  always_ff @(posedge CLK_100) begin
    if (AVL_CS && AVL_WRITE) begin
      for (int b = 0; b < 4; b++)
        if (AVL_BYTE_EN[b]) r_mem[AVL_ADDR][b*8 +: 8] <= AVL_WRITEDATA[b*8 +: 8];
    end
    if (w_any_gnt) r_ram_q <= r_mem[w_ram_addr];
  end

  always_ff @(posedge CLK_100 or posedge RESET) begin
    if (RESET) r_readdata <= '0;
    else if (AVL_CS && AVL_READ) r_readdata <= r_mem[AVL_ADDR];
  end

  always_ff @(posedge CLK_100 or posedge RESET) begin
    if (RESET) begin
      r_s1_vld   <= 1'b0;
      r_s1_ch    <= '0;
      r_s1_rom   <= 1'b0;
      r_s1_slot  <= '0;
      r_s1_hflip <= 1'b0;
    end else begin
      r_s1_vld   <= w_any_gnt;
      r_s1_ch    <= w_gnt_ch;
      r_s1_rom   <= (w_idx_sel < IW'(ROM_SPRITES));
      r_s1_slot  <= SW'(int'(w_line_sel) % LPW);
      r_s1_hflip <= fetch_hflip[w_gnt_ch];
    end
  end

  // Slot 0 sits in the most significant LINE_W bits of the word.
  assign w_raw      = r_s1_rom ? expand_1bpp(w_font_byte)
                               : r_ram_q[(LPW - 1 - int'(r_s1_slot))*LINE_W +: LINE_W];
  assign w_line_out = r_s1_hflip ? hflip_line(w_raw) : w_raw;

  always_ff @(posedge CLK_100 or posedge RESET) begin
    if (RESET) begin
      r_valid <= '0;
      r_data  <= '0;
    end else begin
      r_valid <= '0;
      if (r_s1_vld) begin
        r_valid[r_s1_ch]                   <= 1'b1;
        r_data[r_s1_ch*LINE_W +: LINE_W]   <= w_line_out;
      end
    end
  end

  assign AVL_READDATA = r_readdata;
  assign fetch_valid  = r_valid;
  assign fetch_data   = r_data;
endmodule
